// File: rtl/timer_pkg.sv
// Purpose: shared widths and mode enum for the timer counter core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package timer_pkg;

    localparam int TMR_CNT_WIDTH_DEF = 8;
    localparam int TMR_PSC_WIDTH_DEF = 4;

    typedef enum logic {
        TMR_CONTINUOUS = 1'b0,
        TMR_ONE_SHOT   = 1'b1
    } tmr_mode_e;

endpackage

// File: rtl/timer_cnt_core_if.sv
// Purpose: control/status bundle of the timer counter core.
// Latency: n/a (wiring only).
// Backpressure: none; all controls are levels or sampled edges.
// Ports: master drives the controls and load/compare/prescale values;
//        slave (the core) returns cnt, the sticky flags and running.
interface timer_cnt_core_if
    import timer_pkg::*;
#(
    parameter int CNT_WIDTH = TMR_CNT_WIDTH_DEF,
    parameter int PSC_WIDTH = TMR_PSC_WIDTH_DEF
);
    logic                 clk_in;
    logic                 enable;
    logic                 up_down;
    logic                 one_shot;
    logic                 load_tdr;
    logic [CNT_WIDTH-1:0] tdr_reg;
    logic [CNT_WIDTH-1:0] cmp_reg;
    logic [PSC_WIDTH-1:0] psc_val;
    logic                 clr_ovf;
    logic                 clr_udf;
    logic                 clr_cmp;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 s_ovf;
    logic                 s_udf;
    logic                 s_cmp;
    logic                 running;

    modport master (
        output clk_in, enable, up_down, one_shot, load_tdr, tdr_reg, cmp_reg,
               psc_val, clr_ovf, clr_udf, clr_cmp,
        input  cnt, s_ovf, s_udf, s_cmp, running
    );

    modport slave (
        input  clk_in, enable, up_down, one_shot, load_tdr, tdr_reg, cmp_reg,
               psc_val, clr_ovf, clr_udf, clr_cmp,
        output cnt, s_ovf, s_udf, s_cmp, running
    );
endinterface

// File: rtl/edge_det.sv
// Purpose: 1-bit rising-edge detector on pclk.
// Latency: rise is combinational from din against a one-flop delayed copy.
// Backpressure: none.
// Ports: din in, rise out (high for the cycle din is 1 and was 0 last cycle).
module edge_det (
    input  logic pclk,
    input  logic presetn,
    input  logic din,
    output logic rise
);
    logic din_d;

    // Resetting the delayed copy to 0 makes a level already high at
    // reset release count as an edge.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            din_d <= 1'b0;
        end else begin
            din_d <= din;
        end
    end

    assign rise = din & ~din_d;
endmodule

// File: rtl/timer_cnt_core.sv
// Purpose: prescaled up/down timer counter with load, compare and one-shot mode.
// Latency: cnt updates on the same pclk edge that samples the clk_in rising edge.
// Backpressure: none; enable low freezes cnt and the prescaler.
// Ports: pclk/presetn plain; all controls and status travel on bus (slave).
module timer_cnt_core
    import timer_pkg::*;
#(
    parameter int CNT_WIDTH = TMR_CNT_WIDTH_DEF,
    parameter int PSC_WIDTH = TMR_PSC_WIDTH_DEF
) (
    input  logic             pclk,
    input  logic             presetn,
    timer_cnt_core_if.slave  bus
);
    logic                 clk_edge;
    logic                 ld_edge;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_step;
    logic [PSC_WIDTH-1:0] psc_cnt;
    logic [PSC_WIDTH-1:0] psc_nxt;
    logic                 cnt_tick;
    logic                 tick;
    logic                 done;
    logic                 running;
    logic                 ovf_evt;
    logic                 udf_evt;
    logic                 cmp_evt;
    logic                 s_ovf_q;
    logic                 s_udf_q;
    logic                 s_cmp_q;
    tmr_mode_e            mode;

    edge_det u_clk_edge (
        .pclk    (pclk),
        .presetn (presetn),
        .din     (bus.clk_in),
        .rise    (clk_edge)
    );

    edge_det u_ld_edge (
        .pclk    (pclk),
        .presetn (presetn),
        .din     (bus.load_tdr),
        .rise    (ld_edge)
    );

    assign mode    = bus.one_shot ? TMR_ONE_SHOT : TMR_CONTINUOUS;
    assign running = bus.enable & ~done;

    always_comb begin
        psc_nxt  = psc_cnt;
        cnt_tick = 1'b0;
        if (clk_edge && running) begin
            // >= rather than == so a psc_val lowered mid-period still wraps.
            if (psc_cnt >= bus.psc_val) begin
                psc_nxt  = '0;
                cnt_tick = 1'b1;
            end else begin
                psc_nxt  = psc_cnt + PSC_WIDTH'(1);
            end
        end
        // A load swallows a coincident tick, so it can raise no flag.
        tick     = cnt_tick & ~ld_edge;
        cnt_step = bus.up_down ? (cnt_q + CNT_WIDTH'(1)) : (cnt_q - CNT_WIDTH'(1));
        ovf_evt  = tick &  bus.up_down & (cnt_q == '1);
        udf_evt  = tick & ~bus.up_down & (cnt_q == '0);
        cmp_evt  = tick & (cnt_step == bus.cmp_reg);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q   <= '0;
            psc_cnt <= '0;
            done    <= 1'b0;
            s_ovf_q <= 1'b0;
            s_udf_q <= 1'b0;
            s_cmp_q <= 1'b0;
        end else begin
            if (ld_edge) begin
                cnt_q   <= bus.tdr_reg;
                psc_cnt <= '0;
            end else begin
                if (tick) begin
                    cnt_q <= cnt_step;
                end
                psc_cnt <= psc_nxt;
            end

            // Dropping enable re-arms a finished one-shot.
            if (ld_edge || !bus.enable) begin
                done <= 1'b0;
            end else if (mode == TMR_ONE_SHOT && (ovf_evt || udf_evt)) begin
                done <= 1'b1;
            end

            // Set wins over a clear sampled in the same cycle.
            s_ovf_q <= ovf_evt | (s_ovf_q & ~bus.clr_ovf);
            s_udf_q <= udf_evt | (s_udf_q & ~bus.clr_udf);
            s_cmp_q <= cmp_evt | (s_cmp_q & ~bus.clr_cmp);
        end
    end

    assign bus.cnt     = cnt_q;
    assign bus.s_ovf   = s_ovf_q;
    assign bus.s_udf   = s_udf_q;
    assign bus.s_cmp   = s_cmp_q;
    assign bus.running = running;
endmodule

// File: tb/tb_timer_cnt_core.sv
// Purpose: directed self-checking bench for timer_cnt_core.
// Latency: inputs change on negedge, outputs sampled on negedge.
// Backpressure: n/a.
module tb_timer_cnt_core;
    logic pclk;
    logic presetn;
    int   checks;
    int   errors;

    timer_cnt_core_if #(.CNT_WIDTH(8), .PSC_WIDTH(4)) bus ();

    timer_cnt_core #(.CNT_WIDTH(8), .PSC_WIDTH(4)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus.slave)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Called at a negedge: drive clk_in/load_tdr for one pclk, then drop.
    task automatic step(input logic ck, input logic ld);
        bus.clk_in   = ck;
        bus.load_tdr = ld;
        @(negedge pclk);
        bus.clk_in   = 1'b0;
        bus.load_tdr = 1'b0;
        @(negedge pclk);
    endtask

    task automatic load(input logic [7:0] v);
        bus.tdr_reg = v;
        step(1'b0, 1'b1);
    endtask

    task automatic test_reset;
        presetn      = 1'b0;
        bus.clk_in   = 1'b0;
        bus.enable   = 1'b0;
        bus.up_down  = 1'b1;
        bus.one_shot = 1'b0;
        bus.load_tdr = 1'b0;
        bus.tdr_reg  = 8'h00;
        bus.cmp_reg  = 8'hAA;
        bus.psc_val  = 4'd0;
        bus.clr_ovf  = 1'b0;
        bus.clr_udf  = 1'b0;
        bus.clr_cmp  = 1'b0;
        #3;
        checks++;
        if ({bus.cnt, bus.s_ovf, bus.s_udf, bus.s_cmp, bus.running} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state got cnt=%h ovf=%b udf=%b cmp=%b run=%b want all 0",
                     bus.cnt, bus.s_ovf, bus.s_udf, bus.s_cmp, bus.running);
        end
        bus.enable = 1'b1;
        #1;
        checks++;
        if (bus.running !== 1'b1) begin
            errors++;
            $display("FAIL reset_running got %b want 1", bus.running);
        end
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
    endtask

    task automatic test_prescale;
        logic [7:0] exp;
        bus.psc_val = 4'd3;
        bus.up_down = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            exp = 8'((i + 1) / 4);
            checks++;
            if (bus.cnt !== exp) begin
                errors++;
                $display("FAIL prescale_edge%0d got %h want %h", i, bus.cnt, exp);
            end
        end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_cnt [3];
        logic       exp_ovf [3];
        exp_cnt = '{8'hFF, 8'h00, 8'h01};
        exp_ovf = '{1'b0, 1'b1, 1'b1};
        bus.psc_val = 4'd0;
        load(8'hFE);
        checks++;
        if (bus.cnt !== 8'hFE || bus.s_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_load got cnt=%h ovf=%b want FE 0", bus.cnt, bus.s_ovf);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (bus.cnt !== exp_cnt[i] || bus.s_ovf !== exp_ovf[i] || bus.s_udf !== 1'b0) begin
                errors++;
                $display("FAIL ovf_edge%0d got cnt=%h ovf=%b udf=%b want %h %b 0",
                         i, bus.cnt, bus.s_ovf, bus.s_udf, exp_cnt[i], exp_ovf[i]);
            end
        end
        bus.clr_ovf = 1'b1;
        @(negedge pclk);
        bus.clr_ovf = 1'b0;
        checks++;
        if (bus.s_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b want 0", bus.s_ovf);
        end
    endtask

    task automatic test_one_shot;
        bus.one_shot = 1'b1;
        bus.up_down  = 1'b0;
        load(8'h01);
        step(1'b1, 1'b0);
        checks++;
        if (bus.cnt !== 8'h00 || bus.running !== 1'b1) begin
            errors++;
            $display("FAIL os_first got cnt=%h run=%b want 00 1", bus.cnt, bus.running);
        end
        step(1'b1, 1'b0);
        checks++;
        if (bus.cnt !== 8'hFF || bus.s_udf !== 1'b1 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL os_wrap got cnt=%h udf=%b run=%b want FF 1 0",
                     bus.cnt, bus.s_udf, bus.running);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (bus.cnt !== 8'hFF) begin
            errors++;
            $display("FAIL os_hold got %h want FF", bus.cnt);
        end
        bus.enable = 1'b0;
        @(negedge pclk);
        bus.enable = 1'b1;
        #1;
        checks++;
        if (bus.running !== 1'b1) begin
            errors++;
            $display("FAIL os_rearm got run=%b want 1", bus.running);
        end
        @(negedge pclk);
        step(1'b1, 1'b0);
        checks++;
        if (bus.cnt !== 8'hFE || bus.s_udf !== 1'b1 || bus.s_ovf !== 1'b0) begin
            errors++;
            $display("FAIL os_resume got cnt=%h udf=%b ovf=%b want FE 1 0",
                     bus.cnt, bus.s_udf, bus.s_ovf);
        end
        bus.one_shot = 1'b0;
        bus.clr_udf  = 1'b1;
        @(negedge pclk);
        bus.clr_udf  = 1'b0;
        checks++;
        if (bus.s_udf !== 1'b0) begin
            errors++;
            $display("FAIL udf_clear got %b want 0", bus.s_udf);
        end
    endtask

    task automatic test_compare;
        bus.cmp_reg = 8'h05;
        bus.up_down = 1'b1;
        load(8'h03);
        step(1'b1, 1'b0);
        checks++;
        if (bus.cnt !== 8'h04 || bus.s_cmp !== 1'b0) begin
            errors++;
            $display("FAIL cmp_before got cnt=%h cmp=%b want 04 0", bus.cnt, bus.s_cmp);
        end
        step(1'b1, 1'b0);
        checks++;
        if (bus.cnt !== 8'h05 || bus.s_cmp !== 1'b1) begin
            errors++;
            $display("FAIL cmp_match got cnt=%h cmp=%b want 05 1", bus.cnt, bus.s_cmp);
        end
        bus.clr_cmp = 1'b1;
        @(negedge pclk);
        bus.clr_cmp = 1'b0;
        load(8'h05);
        checks++;
        if (bus.cnt !== 8'h05 || bus.s_cmp !== 1'b0) begin
            errors++;
            $display("FAIL cmp_load got cnt=%h cmp=%b want 05 0", bus.cnt, bus.s_cmp);
        end
        load(8'h04);
        bus.clr_cmp = 1'b1;
        bus.clk_in  = 1'b1;
        @(negedge pclk);
        checks++;
        if (bus.cnt !== 8'h05 || bus.s_cmp !== 1'b1) begin
            errors++;
            $display("FAIL cmp_set_wins got cnt=%h cmp=%b want 05 1", bus.cnt, bus.s_cmp);
        end
        bus.clr_cmp = 1'b0;
        bus.clk_in  = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_load_collision;
        bus.psc_val = 4'd1;
        load(8'h10);
        step(1'b1, 1'b0);
        checks++;
        if (bus.cnt !== 8'h10) begin
            errors++;
            $display("FAIL coll_pre got %h want 10", bus.cnt);
        end
        bus.tdr_reg = 8'h20;
        step(1'b1, 1'b1);
        checks++;
        if (bus.cnt !== 8'h20) begin
            errors++;
            $display("FAIL coll_load got %h want 20", bus.cnt);
        end
        // Prescaler restarted from 0: first edge must not tick, second must.
        step(1'b1, 1'b0);
        checks++;
        if (bus.cnt !== 8'h20) begin
            errors++;
            $display("FAIL coll_psc0 got %h want 20", bus.cnt);
        end
        step(1'b1, 1'b0);
        checks++;
        if (bus.cnt !== 8'h21) begin
            errors++;
            $display("FAIL coll_psc1 got %h want 21", bus.cnt);
        end
    endtask

    task automatic test_async_reset;
        bus.psc_val = 4'd0;
        load(8'hFF);
        step(1'b1, 1'b0);
        checks++;
        if (bus.cnt !== 8'h00 || bus.s_ovf !== 1'b1 || bus.s_cmp !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre got cnt=%h ovf=%b cmp=%b want 00 1 1",
                     bus.cnt, bus.s_ovf, bus.s_cmp);
        end
        step(1'b1, 1'b0);
        #2;
        presetn = 1'b0;
        #1;
        checks++;
        if (bus.cnt !== 8'h00 || bus.s_ovf !== 1'b0 || bus.s_udf !== 1'b0 || bus.s_cmp !== 1'b0) begin
            errors++;
            $display("FAIL arst_now got cnt=%h ovf=%b udf=%b cmp=%b want 00 0 0 0",
                     bus.cnt, bus.s_ovf, bus.s_udf, bus.s_cmp);
        end
        bus.clk_in = 1'b1;
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        bus.clk_in = 1'b0;
        checks++;
        if (bus.cnt !== 8'h01) begin
            errors++;
            $display("FAIL arst_high_clk got %h want 01", bus.cnt);
        end
        @(negedge pclk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_prescale();
        test_overflow();
        test_one_shot();
        test_compare();
        test_load_collision();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/timer_cnt_core.md
TIMER_CNT_CORE -- requirements
Module: timer_cnt_core

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 8, giving the counter and the tdr/compare data width (legal range 2..32).
REQ-002 The block SHALL have parameter PSC_WIDTH, default 4, giving the prescaler divide-value width (legal range 1..16).
REQ-003 The block SHALL have port pclk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port presetn, input, 1, the reset: asynchronous assert, active-low.
REQ-005 The block SHALL have port clk_in, input, 1, the external count clock, sampled on pclk; only its rising edges are used.
REQ-006 The block SHALL have port enable, input, 1, the count enable.
REQ-007 The block SHALL have port up_down, input, 1, the direction: 1 counts up, 0 counts down.
REQ-008 The block SHALL have port one_shot, input, 1, the mode select: 0 continuous, 1 one-shot.
REQ-009 The block SHALL have port load_tdr, input, 1; a rising edge loads tdr_reg into the counter.
REQ-010 The block SHALL have port tdr_reg, input, CNT_WIDTH, the load value.
REQ-011 The block SHALL have port cmp_reg, input, CNT_WIDTH, the compare value.
REQ-012 The block SHALL have port psc_val, input, PSC_WIDTH, the prescaler divide value; the divide ratio is psc_val+1.
REQ-013 The block SHALL have ports clr_ovf, clr_udf and clr_cmp, each input, 1, level-sensitive clears for the matching flag.
REQ-014 The block SHALL have port cnt, output, CNT_WIDTH, the counter value.
REQ-015 The block SHALL have ports s_ovf, s_udf and s_cmp, each output, 1, sticky overflow, underflow and compare-match flags.
REQ-016 The block SHALL have port running, output, 1, high while the counter is allowed to advance.

Function
REQ-017 The block SHALL form clk_edge = clk_in & ~clk_in_d and ld_edge = load_tdr & ~load_tdr_d, where clk_in_d and load_tdr_d are clk_in and load_tdr delayed by one pclk flop.
REQ-018 The prescaler counter psc_cnt SHALL advance on clk_edge only while running=1.
- When psc_cnt >= psc_val on a clk_edge, psc_cnt SHALL return to 0 and cnt_tick SHALL pulse for that cycle.
- Consequently psc_val=0 gives one cnt_tick per clk_edge.
REQ-019 On cnt_tick, cnt SHALL update in the same pclk edge: cnt+1 when up_down=1, cnt-1 when up_down=0, with modulo-2^CNT_WIDTH wrap.
REQ-020 Overflow event = cnt_tick & up_down & (cnt == all-ones); this event SHALL set s_ovf on the same edge that cnt wraps to 0.
REQ-021 Underflow event = cnt_tick & ~up_down & (cnt == 0); this event SHALL set s_udf on the same edge that cnt wraps to all-ones.
REQ-022 s_cmp SHALL be set on the edge at which cnt takes, via cnt_tick, a next value equal to cmp_reg.
- A load or reset that produces cmp_reg SHALL NOT set s_cmp.
REQ-023 A flag SHALL remain set until its clr_* input is sampled high; if a set event and its clear occur in the same cycle, set SHALL win.
REQ-024 ld_edge SHALL have priority over cnt_tick.
- On ld_edge: cnt <= tdr_reg, psc_cnt <= 0, and the one-shot done state is cleared.
- No flag SHALL change due to the load.
REQ-025 In one-shot mode, an overflow or underflow event SHALL set done; running = enable & ~done.
- done SHALL clear when enable is low or on ld_edge.
- The counter SHALL still wrap on the terminating event, then hold.
REQ-026 When enable=0, cnt and psc_cnt SHALL hold their values; flags SHALL still respond to clr_*.
REQ-027 Changes to up_down, one_shot, psc_val or cmp_reg SHALL take effect at the next cnt_tick, with no restart.

Reset
REQ-028 While presetn=0, the block SHALL force cnt=0, psc_cnt=0, s_ovf=s_udf=s_cmp=0, done=0, clk_in_d=0 and load_tdr_d=0 asynchronously.
REQ-029 The running output is combinational and SHALL therefore follow enable after reset.
REQ-030 Because clk_in_d and load_tdr_d reset to 0, a clk_in or load_tdr input already high at reset release SHALL be treated as a rising edge.

Structure
REQ-031 Package timer_pkg SHALL hold the default widths and a mode enum (TMR_CONTINUOUS, TMR_ONE_SHOT).
REQ-032 A sub-module edge_det (1-bit rising-edge detector, pclk/presetn) SHALL be instantiated twice, once for clk_in and once for load_tdr.

Verification
REQ-033 The bench SHALL cover: psc_val=3, up, enable=1, 8 clk_in edges -> cnt 0->2, with one cnt_tick every 4th edge.
REQ-034 The bench SHALL cover: load tdr=0xFE, psc_val=0, up, 3 edges -> cnt FE, FF, 00, 01; s_ovf set on the FF->00 edge; no s_udf.
REQ-035 The bench SHALL cover: one_shot=1, load 0x01, down, 4 edges -> cnt 00, FF, then holds; s_udf=1; running=0. Dropping enable and raising it again -> counting resumes.
REQ-036 The bench SHALL cover: cmp_reg=0x05, load 0x03, up -> s_cmp set when cnt reaches 05. Asserting clr_cmp in the same cycle as a second match -> s_cmp stays 1.
REQ-037 The bench SHALL cover: ld_edge and clk_edge in the same cycle -> cnt = tdr_reg and psc_cnt = 0.
REQ-038 The bench SHALL cover: presetn asserted mid-count -> cnt and all flags are 0 immediately, without waiting for a pclk edge.
